test_result_uart_reporter: RTL and testbench
============================================

// Module: test_result_uart_reporter
// PURPOSE
//  Synthesizable on-chip counterpart of the bench pass/fail check. Watches the core's
//  test-status registers (x26 = end flag, x27 = pass flag, x3 = test number) and, at
//  test end, serially transmits a PASS/FAIL line on a UART TX pin (8N1). Lets FPGA/silicon
//  runs of the ISA test programs report results with no simulator. Sits beside the core in
//  tinyriscv_soc_top and is fed from the selected core's register file.
// PARAMETERS
//  CLK_FREQ     50_000_000  input clock frequency in Hz
//  BAUD         115200      UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer truncation, >= 2)
//  HOLD_CYCLES  5           settle cycles between x26==1 and sampling x27/x3 (>= 1)
// PORTS
//  clk      in   1   system clock
//  rst      in   1   asynchronous reset, active-high
//  x3_i     in   32  test number register (only [7:0] reported)
//  x26_i    in   32  end-of-test flag register; test ends when exactly 32'h1
//  x27_i    in   32  pass flag register; pass when exactly 32'h1
//  tx_o     out  1   UART serial output, idle high
//  busy_o   out  1   high in HOLD and SEND states
//  done_o   out  1   high once the full line has been sent; sticky until rst
//  pass_o   out  1   latched pass result; valid when done_o=1
// BEHAVIOUR
//  Reset (async): state=IDLE, tx_o=1, busy_o=0, done_o=0, pass_o=0, counters=0.
//  FSM states: IDLE -> HOLD -> SEND -> DONE.
//  - IDLE: at a clock edge with x26_i==32'h1 -> HOLD, hold counter cleared.
//  - HOLD: counts HOLD_CYCLES edges. If x26_i!=32'h1 at any edge in HOLD -> back to IDLE
//    (abort, no output). At the HOLD_CYCLES-th edge: latch pass=(x27_i==32'h1) and
//    num=x3_i[7:0], load message, -> SEND; tx_o drives start bit (0) from that edge.
//  - SEND: message bytes sent back to back, no idle gap. Frame = start(0), d[0]..d[7]
//    (LSB first), stop(1); each bit exactly BAUD_DIV cycles, frame = 10*BAUD_DIV cycles.
//    x26_i/x27_i/x3_i ignored. At the edge ending the last stop bit -> DONE.
//  - DONE: tx_o=1, done_o=1, pass_o=latched pass, busy_o=0; absorbing until rst.
//  Messages (ASCII):
//    PASS: "PASS\r\n"                         = 50 41 53 53 0D 0A (6 bytes)
//    FAIL: "FAIL " + hex(num) + "\r\n"        = 46 41 49 4C 20 H1 H0 0D 0A (9 bytes)
//          H1/H0 = upper/lower nibble as uppercase hex ('0'-'9' = 30-39, 'A'-'F' = 41-46).
//  Total SEND time: 60*BAUD_DIV cycles (PASS) or 90*BAUD_DIV cycles (FAIL).
//  pass_o is 0 until DONE (not exposed during SEND).
//  rst mid-HOLD or mid-SEND: tx_o returns high immediately (async), partial frame dropped,
//  FSM in IDLE; a still-asserted x26_i restarts the sequence after rst releases.
//  x26_i values other than exactly 1 (e.g. 32'h3) never trigger.
//  Bit counter, byte index and baud counter are sized by $clog2 of their limits; no wrap
//  beyond their terminal counts.
// TESTING (bench with CLK_FREQ=8, BAUD=1 -> BAUD_DIV=8, HOLD_CYCLES=5)
//  1 PASS: x27=1, x3=0x13, x26 0->1 at edge N -> tx_o low at edge N+5; UART decode gives
//    50 41 53 53 0D 0A; done_o=1, pass_o=1 at edge N+5+480.
//  2 FAIL: x27=0, x3=0x2A -> decode 46 41 49 4C 20 32 41 0D 0A; done_o at N+5+720, pass_o=0.
//  3 HOLD abort: x26=1 for 3 cycles then 0 -> tx_o stays 1, busy_o back to 0, done_o=0;
//    later x26=1 for >=5 cycles -> normal full message.
//  4 Late change: x27 1->0 and x3 changed after SEND begins -> message still "PASS\r\n",
//    pass_o=1; x26 toggled in DONE -> no new output.
//  5 Reset mid-SEND: assert rst during byte 3 -> tx_o=1 same cycle, done_o=0, busy_o=0;
//    release with x26=1 -> full message resent from byte 0.
//  6 Non-trigger: x26=32'h3 held 1000 cycles -> tx_o constant 1, busy_o=0.

Source files
------------

// File: rtl/test_result_uart_reporter.sv
// Watches the core's test-status registers and, once a test ends, sends a PASS/FAIL
// text line over an 8N1 UART so hardware runs can report results without a simulator.
module test_result_uart_reporter #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x3_i,
    input  logic [31:0] x26_i,
    input  logic [31:0] x27_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, SEND, DONE} state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [3:0]          bit_cnt;
    logic [3:0]          byte_idx;
    logic                pass_r;
    logic [7:0]          num_r;
    logic [7:0]          cur_byte;
    logic [3:0]          last_idx;
    logic                unused_x3;

    assign unused_x3 = ^x3_i[31:8];
    assign last_idx  = pass_r ? 4'd5 : 4'd8;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Message text is generated from the latched result rather than stored in a buffer.
    always_comb begin
        cur_byte = 8'h0A;
        if (pass_r) begin
            case (byte_idx)
                4'd0:    cur_byte = 8'h50;
                4'd1:    cur_byte = 8'h41;
                4'd2:    cur_byte = 8'h53;
                4'd3:    cur_byte = 8'h53;
                4'd4:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else begin
            case (byte_idx)
                4'd0:    cur_byte = 8'h46;
                4'd1:    cur_byte = 8'h41;
                4'd2:    cur_byte = 8'h49;
                4'd3:    cur_byte = 8'h4C;
                4'd4:    cur_byte = 8'h20;
                4'd5:    cur_byte = hex_char(num_r[7:4]);
                4'd6:    cur_byte = hex_char(num_r[3:0]);
                4'd7:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            pass_o   <= 1'b0;
            hold_cnt <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            pass_r   <= 1'b0;
            num_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (x26_i == 32'h1) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        busy_o   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (x26_i != 32'h1) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        pass_r   <= (x27_i == 32'h1);
                        num_r    <= x3_i[7:0];
                        state    <= SEND;
                        tx_o     <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                // bit_cnt: 0 = start, 1..8 = data, 9 = stop; tx_o is set for the bit being entered.
                SEND: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_cnt != 4'd9) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_o    <= (bit_cnt < 4'd8) ? cur_byte[bit_cnt[2:0]] : 1'b1;
                        end else if (byte_idx == last_idx) begin
                            state  <= DONE;
                            tx_o   <= 1'b1;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            pass_o <= pass_r;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            bit_cnt  <= '0;
                            tx_o     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_result_uart_reporter.sv
// Self-checking bench for test_result_uart_reporter: decodes the UART line and compares
// received bytes plus state/timing against expectations queued when each test is stimulated.
module tb_test_result_uart_reporter;

    localparam int BIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x3_i = '0;
    logic [31:0] x26_i = '0;
    logic [31:0] x27_i = '0;
    logic        tx_o, busy_o, done_o, pass_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_frame_err = 0;
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift = '0;

    test_result_uart_reporter #(.CLK_FREQ(8), .BAUD(1), .HOLD_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .x3_i(x3_i), .x26_i(x26_i), .x27_i(x27_i),
        .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o)
    );

    always #5 clk = ~clk;

    // UART receiver: sample mid-bit on falling edges, starting from the first low sample.
    always @(negedge clk) begin
        if (rst) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
        end else if (!rx_busy) begin
            if (tx_o === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 3 && tx_o !== 1'b0)
                rx_busy <= 1'b0;
            if (rx_cnt >= 11 && rx_cnt <= 67 && ((rx_cnt - 3) % 8) == 0)
                rx_shift <= {tx_o, rx_shift[7:1]};
            if (rx_cnt == 75) begin
                if (tx_o !== 1'b1)
                    rx_frame_err <= rx_frame_err + 1;
                rx_q.push_back(rx_shift);
                rx_busy <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        x26_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rx_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tx_o, busy_o, done_o, pass_o} !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got tx/busy/done/pass=%b required 1000",
                     {tx_o, busy_o, done_o, pass_o});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({tx_o, busy_o} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL idle_after_reset: got tx/busy=%b required 10", {tx_o, busy_o});
        end
    endtask

    task automatic test_pass();
        int fe0 = rx_frame_err;
        x27_i = 32'h1;
        x3_i  = 32'h13;
        exp_q = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0D, 8'h0A};
        @(negedge clk);
        x26_i = 32'h1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_o, busy_o} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL pass_hold_n4: got tx/busy=%b required 11", {tx_o, busy_o});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({tx_o, busy_o, pass_o} !== 3'b010) begin
            n_err++;
            $display("[TB] FAIL pass_start_n5: got tx/busy/pass=%b required 010", {tx_o, busy_o, pass_o});
        end
        repeat (60 * BIT - 1) @(posedge clk);
        #1;
        n_cmp++;
        if ({done_o, busy_o} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL pass_before_done: got done/busy=%b required 01", {done_o, busy_o});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({tx_o, busy_o, done_o, pass_o} !== 4'b1011) begin
            n_err++;
            $display("[TB] FAIL pass_done: got tx/busy/done/pass=%b required 1011",
                     {tx_o, busy_o, done_o, pass_o});
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size() || rx_frame_err != fe0) begin
            n_err++;
            $display("[TB] FAIL pass_len: got %0d bytes (%0d framing errs) required %0d",
                     rx_q.size(), rx_frame_err - fe0, exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] r = rx_q.pop_front();
            n_cmp++;
            if (r !== e) begin
                n_err++;
                $display("[TB] FAIL pass_byte: got %h required %h", r, e);
            end
        end
        do_reset();
    endtask

    task automatic test_fail();
        x27_i = 32'h0;
        x3_i  = 32'hFFFF_FF2A;
        exp_q = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h20, 8'h32, 8'h41, 8'h0D, 8'h0A};
        @(negedge clk);
        x26_i = 32'h1;
        @(posedge clk);
        repeat (5 + 90 * BIT - 1) @(posedge clk);
        #1;
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL fail_early_done: got done=%b required 0", done_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy_o, done_o, pass_o} !== 3'b010) begin
            n_err++;
            $display("[TB] FAIL fail_done: got busy/done/pass=%b required 010", {busy_o, done_o, pass_o});
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_err++;
            $display("[TB] FAIL fail_len: got %0d bytes required %0d", rx_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] r = rx_q.pop_front();
            n_cmp++;
            if (r !== e) begin
                n_err++;
                $display("[TB] FAIL fail_byte: got %h required %h", r, e);
            end
        end
        do_reset();
    endtask

    task automatic test_hold_abort();
        int tx_low = 0;
        int cyc = 0;
        x27_i = 32'h1;
        x3_i  = 32'h7;
        @(negedge clk);
        x26_i = 32'h1;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL abort_busy_hold: got busy=%b required 1", busy_o);
        end
        repeat (2) @(negedge clk);
        x26_i = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_busy_idle: got busy=%b required 0", busy_o);
        end
        repeat (100) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || done_o !== 1'b0) tx_low++;
        end
        n_cmp++;
        if (tx_low != 0 || rx_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL abort_quiet: got %0d bad cycles, %0d bytes required 0, 0", tx_low, rx_q.size());
        end
        exp_q = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0D, 8'h0A};
        x26_i = 32'h1;
        while (done_o !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (done_o !== 1'b1 || rx_q.size() != exp_q.size()) begin
            n_err++;
            $display("[TB] FAIL abort_retry: got done=%b bytes=%0d required 1, %0d", done_o, rx_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] r = rx_q.pop_front();
            n_cmp++;
            if (r !== e) begin
                n_err++;
                $display("[TB] FAIL abort_byte: got %h required %h", r, e);
            end
        end
        do_reset();
    endtask

    task automatic test_late_change();
        int bad = 0;
        int cyc = 0;
        x27_i = 32'h1;
        x3_i  = 32'h55;
        exp_q = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0D, 8'h0A};
        @(negedge clk);
        x26_i = 32'h1;
        repeat (10) @(negedge clk);
        x27_i = 32'h0;
        x3_i  = 32'h99;
        while (done_o !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if ({done_o, pass_o} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL late_pass: got done/pass=%b required 11", {done_o, pass_o});
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_err++;
            $display("[TB] FAIL late_len: got %0d bytes required %0d", rx_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] r = rx_q.pop_front();
            n_cmp++;
            if (r !== e) begin
                n_err++;
                $display("[TB] FAIL late_byte: got %h required %h", r, e);
            end
        end
        x26_i = 32'h0;
        repeat (3) @(negedge clk);
        x26_i = 32'h1;
        repeat (50) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("[TB] FAIL done_absorbing: got %0d bad cycles required 0", bad);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_send();
        int cyc = 0;
        x27_i = 32'h1;
        x3_i  = 32'h1;
        @(negedge clk);
        x26_i = 32'h1;
        @(posedge clk);
        repeat (5 + 3 * 10 * BIT + 2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mid_send_start_bit: got tx=%b required 0", tx_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_o, busy_o, done_o} !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL mid_send_reset: got tx/busy/done=%b required 100", {tx_o, busy_o, done_o});
        end
        repeat (3) @(negedge clk);
        rx_q.delete();
        exp_q = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0D, 8'h0A};
        rst = 1'b0;
        while (done_o !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (done_o !== 1'b1 || rx_q.size() != exp_q.size()) begin
            n_err++;
            $display("[TB] FAIL resend: got done=%b bytes=%0d required 1, %0d", done_o, rx_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] r = rx_q.pop_front();
            n_cmp++;
            if (r !== e) begin
                n_err++;
                $display("[TB] FAIL resend_byte: got %h required %h", r, e);
            end
        end
        do_reset();
    endtask

    task automatic test_non_trigger();
        int bad = 0;
        @(negedge clk);
        x26_i = 32'h3;
        repeat (1000) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("[TB] FAIL non_trigger: got %0d bad cycles required 0", bad);
        end
        do_reset();
    endtask

    initial begin
        $display("[TB] starting");
        test_reset();
        test_pass();
        test_fail();
        test_hold_abort();
        test_late_change();
        test_reset_mid_send();
        test_non_trigger();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
